// File: rtl/decode_issue_pkg.sv
// Shared core definitions for the decode/issue stage: opcode constants,
// opcode classes, FSM states and the decoded-instruction record.
package decode_issue_pkg;

    localparam int UOP_CNT_W = 26;

    localparam logic [UOP_CNT_W-1:0] UOP_NONE   = '0;
    localparam logic [UOP_CNT_W-1:0] UOP_FIRST  = UOP_CNT_W'(1);
    localparam logic [UOP_CNT_W-1:0] UOP_SECOND = UOP_CNT_W'(2);

    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_NOP  = 5'b00001;
    localparam logic [4:0] OP_JAL  = 5'b00110;
    localparam logic [4:0] OP_JALR = 5'b00111;
    localparam logic [4:0] OP_ST   = 5'b10000;
    localparam logic [4:0] OP_LD   = 5'b10001;
    localparam logic [4:0] OP_STU  = 5'b10011;
    localparam logic [4:0] OP_ADD  = 5'b11011;

    // How an opcode is routed to execute.
    typedef enum logic [2:0] {
        CLS_EXEC,
        CLS_LDST,
        CLS_JMP,
        CLS_BRANCH,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_MULTI,
        ST_HALTED
    } state_e;

    // Everything the issue stage needs to know about one fetched instruction.
    typedef struct packed {
        logic [4:0] opcode;
        logic [2:0] rs;
        logic [2:0] rt;
        logic [2:0] rd;
        op_class_e  cls;
        logic       two_uop;
    } dec_t;

    // R-type ALU opcodes take their destination from instr[4:2].
    function automatic logic is_rtype(input logic [4:0] opcode);
        return (opcode == OP_ADD) || (opcode[4:2] == 3'b111);
    endfunction

endpackage

// File: rtl/decode_table.sv
// Purely combinational opcode decoder: field extraction, class, rd select
// and the number of uops each instruction expands into.
module decode_table
    import decode_issue_pkg::*;
(
    input  logic [15:0] instr,
    output dec_t        dec
);

    // Classify the opcode and pick the destination register field.
    always_comb begin
        dec.opcode  = instr[15:11];
        dec.rs      = instr[10:8];
        dec.rt      = instr[7:5];
        dec.rd      = is_rtype(instr[15:11]) ? instr[4:2] : instr[7:5];
        dec.cls     = CLS_ILLEGAL;
        dec.two_uop = 1'b0;

        casez (instr[15:11])
            5'b00000: dec.cls = CLS_HALT;
            5'b00001: dec.cls = CLS_NOP;
            5'b001??: begin
                dec.cls     = CLS_JMP;
                // JAL and JALR write the link register as a separate uop.
                dec.two_uop = (instr[15:11] == OP_JAL) || (instr[15:11] == OP_JALR);
            end
            5'b011??: dec.cls = CLS_BRANCH;
            5'b10000,
            5'b10001: dec.cls = CLS_LDST;
            5'b10011: begin
                // Store-with-update: the store plus the base-register update.
                dec.cls     = CLS_LDST;
                dec.two_uop = 1'b1;
            end
            5'b11011,
            5'b111??: dec.cls = CLS_EXEC;
            default:  dec.cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: accepts one fetched instruction at a time, expands it
// into one or two uops and presents them on a registered idix interface.
module decode_issue
    import decode_issue_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          instr_ifid_p1,
    input  logic [15:0]          pc_ifid_p1,
    input  logic                 valid_ifid_p1,
    output logic                 ready_ifid,
    input  logic                 stall_ix,
    input  logic                 flush_ix,
    output logic [15:0]          pc_p1,
    output logic [2:0]           rs_idix_p1,
    output logic [2:0]           rt_idix_p1,
    output logic [2:0]           rd_idix_p1,
    output logic [4:0]           opcode_idix_p1,
    output logic [UOP_CNT_W-1:0] uop_cnt_idix_p1,
    output logic                 execute_valid_idix_p1,
    output logic                 ldst_valid_idix_p1,
    output logic                 jmp_idix_p1,
    output logic                 branch_idix_p1,
    output logic                 illegal_idix_p1
);

    dec_t dec;

    state_e               state_q,   state_d;
    logic [15:0]          pc_q,      pc_d;
    logic [2:0]           rs_q,      rs_d;
    logic [2:0]           rt_q,      rt_d;
    logic [2:0]           rd_q,      rd_d;
    logic [4:0]           opcode_q,  opcode_d;
    logic [UOP_CNT_W-1:0] uop_cnt_q, uop_cnt_d;
    logic                 exec_q,    exec_d;
    logic                 ldst_q,    ldst_d;
    logic                 jmp_q,     jmp_d;
    logic                 branch_q,  branch_d;
    logic                 illegal_q, illegal_d;
    logic                 two_q,     two_d;    // presented instr has a second uop
    logic                 halt_q,    halt_d;   // presented uop is HALT

    logic accept;
    logic load_new;
    logic go_bubble;

    decode_table u_decode_table (
        .instr (instr_ifid_p1),
        .dec   (dec)
    );

    // Handshake: take a new instruction only when the presented uop (if any)
    // leaves this cycle and nothing else of it remains. A presented HALT
    // also blocks fetch so nothing is accepted behind it and then lost.
    always_comb begin
        ready_ifid = !rst && !flush_ix && !stall_ix && (state_q != ST_HALTED)
                     && !((state_q == ST_ISSUE) && (two_q || halt_q));
        accept     = valid_ifid_p1 && ready_ifid;
    end

    // Next-state and next idix register contents.
    always_comb begin
        // NOTE: every _d takes its _q value first, so any path that does not
        // assign it holds state instead of inferring a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        opcode_d  = opcode_q;
        uop_cnt_d = uop_cnt_q;
        exec_d    = exec_q;
        ldst_d    = ldst_q;
        jmp_d     = jmp_q;
        branch_d  = branch_q;
        illegal_d = illegal_q;
        two_d     = two_q;
        halt_d    = halt_q;
        load_new  = 1'b0;
        go_bubble = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) load_new = 1'b1;
            end
            ST_ISSUE: begin
                if (!stall_ix) begin
                    if (two_q) begin
                        // Second uop: same fields, only the index moves.
                        uop_cnt_d = UOP_SECOND;
                        two_d     = 1'b0;
                        state_d   = ST_MULTI;
                    end else if (halt_q) begin
                        go_bubble = 1'b1;
                        state_d   = ST_HALTED;
                    end else if (accept) begin
                        load_new = 1'b1;
                    end else begin
                        go_bubble = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_MULTI: begin
                if (!stall_ix) begin
                    if (accept) begin
                        load_new = 1'b1;
                    end else begin
                        go_bubble = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_HALTED: begin
                // Only reset leaves HALTED; the register already holds a bubble.
            end
            default: begin
                go_bubble = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase

        // A redirect kills whatever is in flight, except that HALTED is sticky.
        if (flush_ix && (state_q != ST_HALTED)) begin
            load_new  = 1'b0;
            go_bubble = 1'b1;
            state_d   = ST_IDLE;
        end

        if (load_new) begin
            state_d   = ST_ISSUE;
            pc_d      = pc_ifid_p1;
            rs_d      = dec.rs;
            rt_d      = dec.rt;
            rd_d      = dec.rd;
            opcode_d  = dec.opcode;
            uop_cnt_d = UOP_FIRST;
            exec_d    = (dec.cls == CLS_EXEC) || (dec.cls == CLS_HALT);
            ldst_d    = (dec.cls == CLS_LDST);
            jmp_d     = (dec.cls == CLS_JMP);
            branch_d  = (dec.cls == CLS_BRANCH);
            illegal_d = (dec.cls == CLS_ILLEGAL);
            two_d     = dec.two_uop;
            halt_d    = (dec.cls == CLS_HALT);
        end

        if (go_bubble) begin
            uop_cnt_d = UOP_NONE;
            exec_d    = 1'b0;
            ldst_d    = 1'b0;
            jmp_d     = 1'b0;
            branch_d  = 1'b0;
            illegal_d = 1'b0;
            two_d     = 1'b0;
            halt_d    = 1'b0;
        end
    end

    // State and idix register, synchronous reset overriding everything.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            opcode_q  <= '0;
            uop_cnt_q <= UOP_NONE;
            exec_q    <= 1'b0;
            ldst_q    <= 1'b0;
            jmp_q     <= 1'b0;
            branch_q  <= 1'b0;
            illegal_q <= 1'b0;
            two_q     <= 1'b0;
            halt_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            opcode_q  <= opcode_d;
            uop_cnt_q <= uop_cnt_d;
            exec_q    <= exec_d;
            ldst_q    <= ldst_d;
            jmp_q     <= jmp_d;
            branch_q  <= branch_d;
            illegal_q <= illegal_d;
            two_q     <= two_d;
            halt_q    <= halt_d;
        end
    end

    // Registered idix outputs.
    always_comb begin
        pc_p1                 = pc_q;
        rs_idix_p1            = rs_q;
        rt_idix_p1            = rt_q;
        rd_idix_p1            = rd_q;
        opcode_idix_p1        = opcode_q;
        uop_cnt_idix_p1       = uop_cnt_q;
        execute_valid_idix_p1 = exec_q;
        ldst_valid_idix_p1    = ldst_q;
        jmp_idix_p1           = jmp_q;
        branch_idix_p1        = branch_q;
        illegal_idix_p1       = illegal_q;
    end

endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock; rst  in  1  synchronous active-high reset.
REQ-002 SHALL have ports: instr_ifid_p1  in  16  fetched instruction; pc_ifid_p1  in  16  its PC; valid_ifid_p1  in  1  fetch slot valid.
REQ-003 SHALL have ports: ready_ifid  out  1  decode accepts fetch slot this cycle.
REQ-004 SHALL have ports: stall_ix  in  1  execute cannot take a uop; flush_ix  in  1  redirect, kill in-flight decode.
REQ-005 SHALL have ports: pc_p1  out  16; rs_idix_p1, rt_idix_p1, rd_idix_p1  out  3 each; opcode_idix_p1  out  5.
REQ-006 SHALL have ports: uop_cnt_idix_p1  out  26  one-hot uop index; execute_valid_idix_p1, ldst_valid_idix_p1, jmp_idix_p1, branch_idix_p1, illegal_idix_p1  out  1 each.

Function
REQ-007 SHALL accept an instruction when valid_ifid_p1 && ready_ifid; all outputs SHALL be registered, with first uop on the idix outputs the cycle after acceptance (latency 1).
REQ-008 SHALL decode opcode=instr[15:11], rs=instr[10:8], rt=instr[7:5]; rd=instr[4:2] for R-type ALU (5'b11011, 5'b11100-11111), else rd=instr[7:5].
REQ-009 SHALL classify: 5'b10000 ST, 5'b10001 LD, 5'b10011 STU -> ldst_valid=1; 5'b011xx -> branch_idix_p1=1; 5'b001xx -> jmp_idix_p1=1; all other legal opcodes -> execute_valid=1.
REQ-010 SHALL issue STU, JAL (5'b00110) and JALR (5'b00111) as two uops, all others as one; uop_cnt_idix_p1 SHALL be 26'h1 for uop 0 and 26'h2 for uop 1; all other fields SHALL stay constant across uops.
REQ-011 SHALL drive uop_cnt_idix_p1=0 and all *_valid/jmp/branch/illegal flags 0 in any cycle with no uop issued (bubble).
REQ-012 SHALL implement FSM IDLE, ISSUE, MULTI, HALTED: IDLE->ISSUE on accept; ISSUE->MULTI when the instruction needs a second uop and stall_ix=0; MULTI->ISSUE/IDLE after the second uop leaves, depending on a new accept; ISSUE->HALTED on HALT (5'b00000) leaving.
REQ-013 SHALL drive ready_ifid = !stall_ix && state!=HALTED && !(state==ISSUE && current instruction needs a second uop).
REQ-014 SHALL hold every idix output unchanged while stall_ix=1 and a uop is presented (uop_cnt!=0).
REQ-015 flush_ix SHALL take priority over stall_ix and accept: next cycle all flags 0, uop_cnt 0, state IDLE; an instruction presented in the flush cycle SHALL be dropped; ready_ifid SHALL be 0 during flush.
REQ-016 An opcode outside the REQ-009/010/HALT/NOP(5'b00001)/ALU sets SHALL issue one uop with illegal_idix_p1=1 and execute_valid/ldst/jmp/branch=0.
REQ-017 HALTED SHALL deassert ready_ifid and issue only bubbles until rst; flush_ix SHALL NOT leave HALTED.
REQ-018 NOP SHALL issue one uop with execute_valid=0 and all other flags 0.

Reset
REQ-019 On rst=1 at a clk edge: state IDLE; pc_p1, rs/rt/rd, opcode, uop_cnt all 0; all flags 0; ready_ifid 0 during the rst cycle.
REQ-020 rst SHALL override flush_ix, stall_ix and any in-progress MULTI sequence.

Structure
REQ-021 Opcode constants, opcode-class enum, FSM state enum and uop-count width (26) SHALL live in the shared core package.
REQ-022 Opcode-to-class/rd-select/uop-count logic SHALL be one combinational sub-module, decode_table; the FSM and idix register SHALL be in decode_issue.

Verification
REQ-023 ADD R-type 16'hD9A8, pc 16'h0040, no stall -> next cycle opcode 5'b11011, rs 1, rt 5, rd 2, uop_cnt 26'h1, execute_valid 1.
REQ-024 STU 16'h9A40 -> two consecutive uops, uop_cnt 26'h1 then 26'h2, ldst_valid 1 both, ready_ifid 0 in the first uop cycle.
REQ-025 LD accepted, stall_ix held 3 cycles -> idix outputs identical for all 3 cycles, then a new instruction is accepted when stall drops.
REQ-026 JAL first uop out, flush_ix=1 -> next cycle uop_cnt 0, jmp 0, state IDLE; second uop never appears.
REQ-027 HALT 16'h0000 then valid BEQZ 16'h6000 -> ready_ifid stays 0, only bubbles until rst; after rst a fresh accept works.
REQ-028 Opcode 5'b01111 illegal check vs REQ-009 overlap resolved: opcode 5'b11010 (unused) -> illegal_idix_p1 1, all other flags 0, uop_cnt 26'h1.
